// File: rtl/relu_maxpool2d.sv
// Fused ReLU + max-pool: walks every POOL x POOL window of every channel in the conv buffer
// and writes max(0, window max) into the pool buffer, pulsing done after the last write.
module relu_maxpool2d #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 8,
   parameter int IMG_SIZE   = 28,
   parameter int POOL       = 2,
   localparam int OUT  = IMG_SIZE / POOL,
   localparam int CA_W = $clog2(CHANNELS * IMG_SIZE * IMG_SIZE),
   localparam int PA_W = $clog2(CHANNELS * OUT * OUT)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic [CA_W-1:0]              conv_addr,
   output logic                         conv_en,
   input  logic signed [DATA_WIDTH-1:0] conv_q,
   output logic [PA_W-1:0]              pool_addr,
   output logic                         pool_en,
   output logic                         pool_we,
   output logic signed [DATA_WIDTH-1:0] pool_d,
   output logic                         done
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
   localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;
   localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);
   localparam logic [OW-1:0] OUT_LAST  = OW'(OUT - 1);
   localparam logic [PW-1:0] POOL_LAST = PW'(POOL - 1);

   typedef enum logic [2:0] {IDLE, SCAN, LAST, WRITE, FINISH} state_t;

   state_t r_state, w_nextState;
   logic [CW-1:0] r_c, w_selC;
   logic [OW-1:0] r_pr, r_pc, w_selPr, w_selPc;
   logic [PW-1:0] r_dr, r_dc, w_selDr, w_selDc;
   logic          w_issue;
   logic          r_convEn, r_convEnD, r_poolWe, r_done;
   logic [CA_W-1:0] r_convAddr, w_convAddr;
   logic [PA_W-1:0] r_poolAddr, w_poolAddr;
   logic signed [DATA_WIDTH-1:0] r_max, w_maxNew, r_poolD;

   // w_sel* are the indices of the read issued this cycle; window counters advance on leaving WRITE
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      w_selC      = r_c;
      w_selPr     = r_pr;
      w_selPc     = r_pc;
      w_selDr     = r_dr;
      w_selDc     = r_dc;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = SCAN;
               w_issue     = 1'b1;
               w_selDr     = '0;
               w_selDc     = '0;
            end
         end
         SCAN: begin
            if (r_dr == POOL_LAST && r_dc == POOL_LAST) begin
               w_nextState = LAST;
            end else begin
               w_issue = 1'b1;
               if (r_dc == POOL_LAST) begin
                  w_selDr = r_dr + PW'(1);
                  w_selDc = '0;
               end else begin
                  w_selDc = r_dc + PW'(1);
               end
            end
         end
         LAST: w_nextState = WRITE;
         WRITE: begin
            w_selDr = '0;
            w_selDc = '0;
            if (r_pc != OUT_LAST) begin
               w_selPc = r_pc + OW'(1);
            end else begin
               w_selPc = '0;
               if (r_pr != OUT_LAST) begin
                  w_selPr = r_pr + OW'(1);
               end else begin
                  w_selPr = '0;
                  w_selC  = (r_c != CH_LAST) ? r_c + CW'(1) : '0;
               end
            end
            if (r_c == CH_LAST && r_pr == OUT_LAST && r_pc == OUT_LAST) begin
               w_nextState = FINISH;
            end else begin
               w_nextState = SCAN;
               w_issue     = 1'b1;
            end
         end
         FINISH: w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   assign w_convAddr = (CA_W'(w_selC) * CA_W'(IMG_SIZE) + CA_W'(w_selPr) * CA_W'(POOL) + CA_W'(w_selDr))
                       * CA_W'(IMG_SIZE) + CA_W'(w_selPc) * CA_W'(POOL) + CA_W'(w_selDc);
   assign w_poolAddr = (PA_W'(r_c) * PA_W'(OUT) + PA_W'(r_pr)) * PA_W'(OUT) + PA_W'(r_pc);

   // The running max starts at 0, so the pooled result already includes the ReLU clamp
   assign w_maxNew = (r_convEnD && (conv_q > r_max)) ? conv_q : r_max;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_c        <= '0;
         r_pr       <= '0;
         r_pc       <= '0;
         r_dr       <= '0;
         r_dc       <= '0;
         r_convEn   <= 1'b0;
         r_convEnD  <= 1'b0;
         r_convAddr <= '0;
         r_poolWe   <= 1'b0;
         r_poolAddr <= '0;
         r_poolD    <= '0;
         r_max      <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_c       <= w_selC;
         r_pr      <= w_selPr;
         r_pc      <= w_selPc;
         r_dr      <= w_selDr;
         r_dc      <= w_selDc;
         r_convEn  <= w_issue;
         r_convEnD <= r_convEn;
         if (w_issue)
            r_convAddr <= w_convAddr;
         r_poolWe <= (w_nextState == WRITE);
         r_done   <= (w_nextState == FINISH);
         if (w_nextState == WRITE) begin
            r_poolAddr <= w_poolAddr;
            r_poolD    <= w_maxNew;
            r_max      <= '0;
         end else if (r_convEnD) begin
            r_max <= w_maxNew;
         end
      end
   end

   assign conv_addr = r_convAddr;
   assign conv_en   = r_convEn;
   assign pool_addr = r_poolAddr;
   assign pool_en   = r_poolWe;
   assign pool_we   = r_poolWe;
   assign pool_d    = r_poolD;
   assign done      = r_done;

endmodule

// File: tb/tb_relu_maxpool2d.sv
// Self-checking bench for relu_maxpool2d: BRAM model, window-max reference model,
// table-driven signed-compare windows, random frames and multi-cycle start/reset sequences.
module tb_relu_maxpool2d;

   localparam int DW     = 16;
   localparam int CH     = 2;
   localparam int IMG    = 5;
   localparam int PL     = 2;
   localparam int OUT    = IMG / PL;
   localparam int N      = CH * OUT * OUT;
   localparam int PERIOD = PL * PL + 2;
   localparam int MEMSZ  = CH * IMG * IMG;
   localparam int CAW    = $clog2(CH * IMG * IMG);
   localparam int PAW    = $clog2(CH * OUT * OUT);

   logic clk = 1'b0;
   logic reset, start;
   logic [CAW-1:0] conv_addr;
   logic conv_en;
   logic signed [DW-1:0] conv_q = '0;
   logic [PAW-1:0] pool_addr;
   logic pool_en, pool_we, done;
   logic signed [DW-1:0] pool_d;

   relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IMG), .POOL(PL)) dut (
      .clk(clk), .reset(reset), .start(start),
      .conv_addr(conv_addr), .conv_en(conv_en), .conv_q(conv_q),
      .pool_addr(pool_addr), .pool_en(pool_en), .pool_we(pool_we),
      .pool_d(pool_d), .done(done)
   );

   always #5 clk = ~clk;

   logic signed [DW-1:0] mem [MEMSZ];

   // One-cycle-latency BRAM; garbage on cycles without a read so ignored data is really ignored
   always @(posedge clk) begin
      if (conv_en && int'(conv_addr) < MEMSZ)
         conv_q <= mem[conv_addr];
      else
         conv_q <= DW'($urandom);
   end

   typedef struct {
      logic [DW-1:0] a, b, c, d, exp;
   } vec_t;

   vec_t tbl [N];
   int checks = 0;
   int errors = 0;
   logic signed [DW-1:0] expPool [N];
   logic signed [DW-1:0] got [N];
   int writes, stray;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void buildModel();
      for (int c = 0; c < CH; c++)
         for (int pr = 0; pr < OUT; pr++)
            for (int pc = 0; pc < OUT; pc++) begin
               logic signed [DW-1:0] m;
               m = '0;
               for (int dr = 0; dr < PL; dr++)
                  for (int dc = 0; dc < PL; dc++)
                     if (mem[(c * IMG + pr * PL + dr) * IMG + pc * PL + dc] > m)
                        m = mem[(c * IMG + pr * PL + dr) * IMG + pc * PL + dc];
               expPool[(c * OUT + pr) * OUT + pc] = m;
            end
   endfunction

   function automatic void fillRandom();
      for (int i = 0; i < MEMSZ; i++)
         mem[i] = DW'($urandom);
   endfunction

   // Runs one frame from the current cycle t and checks every cycle up to the return to IDLE
   task automatic applyStimulus(input bit holdStart, input bit busyPulses, output int wr);
      int k, j, c, pr, pc;
      logic expEn, expWe, expDone;
      wr = 0;
      buildModel();
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!holdStart) start = 1'b0;
      for (int n = 1; n <= PERIOD * N + 2; n++) begin
         @(negedge clk);
         k = (n - 1) / PERIOD;
         j = (n - 1) % PERIOD;
         expEn   = (n <= PERIOD * N) && (j < PL * PL);
         expWe   = (n <= PERIOD * N) && (j == PERIOD - 1);
         expDone = (n == PERIOD * N + 1);
         checkOutput("ctrl{en,we,pen,done}", {28'b0, conv_en, pool_we, pool_en, done},
                     {28'b0, expEn, expWe, expWe, expDone});
         if (expEn && conv_en) begin
            c  = k / (OUT * OUT);
            pr = (k / OUT) % OUT;
            pc = k % OUT;
            checkOutput("convAddr", 32'(conv_addr),
                        (c * IMG + pr * PL + j / PL) * IMG + pc * PL + j % PL);
         end
         if (pool_we) begin
            wr++;
            if (expWe) begin
               checkOutput("poolAddr", 32'(pool_addr), k);
               checkOutput("poolD", pool_d, expPool[k]);
               got[k] = pool_d;
            end
         end
         if (!holdStart)
            start = busyPulses && (n < PERIOD * N) && ($urandom_range(0, 3) == 0);
      end
      checkOutput("writeCount", wr, N);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".conv_addr"}, 32'(conv_addr), 0);
      checkOutput({tag, ".conv_en"}, 32'(conv_en), 0);
      checkOutput({tag, ".pool_addr"}, 32'(pool_addr), 0);
      checkOutput({tag, ".pool_en"}, 32'(pool_en), 0);
      checkOutput({tag, ".pool_we"}, 32'(pool_we), 0);
      checkOutput({tag, ".pool_d"}, pool_d, 0);
      checkOutput({tag, ".done"}, 32'(done), 0);
   endtask

   initial begin
      // Element order inside a window: (dr,dc) = (0,0),(0,1),(1,0),(1,1)
      tbl[0] = '{16'hFFFB, 16'h0003, 16'hFFFF, 16'h0002, 16'h0003};
      tbl[1] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
      tbl[2] = '{16'h8000, 16'hFFFF, 16'h8001, 16'hFFFE, 16'h0000};
      tbl[3] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004};
      tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[5] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001};
      tbl[6] = '{16'h7FFE, 16'h0100, 16'h7FFF, 16'h0200, 16'h7FFF};
      tbl[7] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000};

      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Table windows; the odd-size trailing row/col holds random data that must never be read
      fillRandom();
      for (int k = 0; k < N; k++) begin
         int base;
         base = ((k / (OUT * OUT)) * IMG + ((k / OUT) % OUT) * PL) * IMG + (k % OUT) * PL;
         mem[base]           = tbl[k].a;
         mem[base + 1]       = tbl[k].b;
         mem[base + IMG]     = tbl[k].c;
         mem[base + IMG + 1] = tbl[k].d;
      end
      applyStimulus(1'b0, 1'b0, writes);
      for (int k = 0; k < N; k++)
         checkOutput($sformatf("table[%0d]", k), got[k], tbl[k].exp);

      for (int f = 0; f < 3; f++) begin
         fillRandom();
         applyStimulus(1'b0, f > 0, writes);
      end

      for (int i = 0; i < MEMSZ; i++) mem[i] = 16'sh8000;
      applyStimulus(1'b0, 1'b1, writes);
      for (int k = 0; k < N; k++)
         checkOutput($sformatf("allNeg[%0d]", k), got[k], 0);

      // Reset the cycle after the second write; nothing may follow until a new start
      fillRandom();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= 2 * PERIOD; n++) begin
         @(negedge clk);
         if (n == 2 * PERIOD) begin
            checkOutput("secondWrite.we", 32'(pool_we), 1);
            checkOutput("secondWrite.addr", 32'(pool_addr), 1);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkAllZero("midReset");
      stray = 0;
      repeat (100) begin
         @(negedge clk);
         if (pool_we || done) stray++;
      end
      checkOutput("noActivityAfterReset", stray, 0);
      applyStimulus(1'b0, 1'b0, writes);

      // Held start gives back-to-back frames with identical sequences
      fillRandom();
      applyStimulus(1'b1, 1'b0, writes);
      applyStimulus(1'b1, 1'b0, writes);
      start = 1'b0;
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (pool_we || done || conv_en) stray++;
      end
      checkOutput("idleAfterHeldStart", stray, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/relu_maxpool2d.md
# relu_maxpool2d

Fused ReLU + 2-D max-pool stage that reads the convolution output buffer BRAM (the write side is filled by the convolution layer) and writes a pooled feature map into the pool buffer BRAM. Runs once per `start` pulse, walks every pooling window of every channel, and pulses `done` when the last pooled value is written. It sits between the convolution layer and the dense/flatten stage.

## Interface
- `DATA_WIDTH`, 16: signed fixed-point sample width. Values pass through unchanged and are not rescaled.
- `CHANNELS`, 8: number of feature-map channels.
- `IMG_SIZE`, 28: input height and width.
- `POOL`, 2: pooling window size and stride.
- Derived `OUT` = `IMG_SIZE/POOL`, using integer division.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  frame start. Sampled only in IDLE.
- `conv_addr`  out  $clog2(CHANNELS*IMG_SIZE*IMG_SIZE)  conv buffer read address
- `conv_en`  out  1  conv buffer read enable
- `conv_q`  in  DATA_WIDTH, signed  conv buffer read data. Valid the cycle after `conv_en` is high.
- `pool_addr`  out  $clog2(CHANNELS*OUT*OUT)  pool buffer write address
- `pool_en`  out  1  pool buffer enable. Always equal to `pool_we`.
- `pool_we`  out  1  pool buffer write strobe
- `pool_d`  out  DATA_WIDTH, signed  pooled value
- `done`  out  1  one-cycle end-of-frame pulse

## Operation
- All outputs are registered. Reset value of every output is 0.
- States:
  - IDLE: `start` moves to SCAN.
  - SCAN: issues POOL*POOL reads.
  - LAST: captures the final read of the window.
  - WRITE: issues one pool write. Goes to SCAN for the next window, or to FINISH after the last window.
  - FINISH: `done` pulse, then back to IDLE.
- Traversal order: channel c is the outer loop, then pooled row pr, then pooled col pc. Inside a window, dr is the outer loop and dc the inner loop, both running 0..POOL-1.
- Read address = (c*IMG_SIZE + pr*POOL+dr)*IMG_SIZE + pc*POOL+dc.
- Write address = (c*OUT + pr)*OUT + pc.
- Running max:
  - Cleared to 0 at the start of each window. This fuses ReLU into the pool.
  - Updated as max(run, conv_q) using signed comparison on the cycles after each `conv_en`.
  - `pool_d` = max(0, window max). An all-negative window yields 0.
  - No saturation is needed: the result is always within [0, 2^(DATA_WIDTH-1)-1].
- `conv_q` is ignored on any cycle not directly following a `conv_en` cycle.
- Odd `IMG_SIZE`: the trailing row and column are never read.
- `start` is ignored outside IDLE. If `start` is still high on return to IDLE, a new frame begins.
- Reset mid-frame:
  - All outputs are 0 on the next cycle and the block returns to IDLE.
  - No further `pool_we` or `done` pulses occur.
  - The next `start` restarts from pool address 0.
- `pool_addr` and `pool_d` hold their values between writes. `conv_addr` holds its value between reads.

## Timing
- `start` is sampled high in IDLE at the edge ending cycle t. Window k (0-based) then runs as follows:
  - `conv_en` is high for cycles t+1+6k .. t+4+6k when POOL=2. In general it is high for POOL*POOL consecutive cycles.
  - A new `conv_addr` is presented each cycle.
  - Cycle t+5+6k: `conv_en` is low. `conv_q` carries the last element of the window.
  - Cycle t+6+6k: `pool_we` = `pool_en` = 1 for exactly one cycle, with `pool_addr` and `pool_d` valid.
- Window period is POOL*POOL+2 cycles. There are no gaps between windows.
- With N = CHANNELS*OUT*OUT, `done` is high in cycle t + N*(POOL*POOL+2) + 1 only.
- With the default parameters: N = 1568, writes end at cycle t+9408, and `done` is high at cycle t+9409.
- The block returns to IDLE the cycle after `done`. It can accept `start` in that cycle.

## Test plan
- Ramp: CHANNELS=1, IMG_SIZE=4, conv[i]=i, pulse `start` at cycle t.
  - Writes are pool[0..3] = 5, 7, 13, 15 at cycles t+6, t+12, t+18, t+24.
  - `done` is high only at cycle t+25.
  - Exactly 16 `conv_en` cycles occur.
- All-negative buffer with every value 0x8000: every pool write is 0. Total writes = CHANNELS*OUT*OUT.
- Signed compare:
  - Window {-5, 3, -1, 2} gives 3.
  - Window {0x7FFF, 0x8000, 0, 1} gives 0x7FFF.
  - Window {0x8000, 0xFFFF, 0x8001, 0xFFFE} gives 0.
- Odd size: IMG_SIZE=5, POOL=2.
  - OUT=2, so 4 writes per channel.
  - No `conv_addr` ever addresses row 4 or col 4.
- Reset mid-frame: assert `reset` for 1 cycle right after the 2nd `pool_we`.
  - All outputs read 0 the next cycle.
  - No further writes occur and `done` never pulses.
  - A new `start` produces its first write at pool_addr 0, 6 cycles after the start edge.
- `start` handling:
  - Pulsing `start` while busy has no effect: exactly one `done` per frame, with timing unchanged.
  - Holding `start` high continuously gives back-to-back frames, each with an identical write sequence.
